// File: rtl/ccd_capture_if.sv
`default_nettype none
// ============================================================================
// Module   : ccd_capture_if
// Brief    : Sensor-side inputs, run control and capture outputs of the
//            CCD capture stage, bundled for connection to ccd_capture.
// Revision : 1.0  initial release
// ============================================================================
interface ccd_capture_if #(
  parameter int DATA_W = 10
);
  logic [DATA_W-1:0] iDATA;
  logic              iFVAL;
  logic              iLVAL;
  logic              iSTART;
  logic              iEND;
  logic [DATA_W-1:0] oDATA;
  logic              oDVAL;
  logic [10:0]       oX_Cont;
  logic [10:0]       oY_Cont;
  logic [31:0]       oFrame_Cont;

  // Sensor / controller side: drives raw pixels and run control.
  modport master (
    output iDATA, iFVAL, iLVAL, iSTART, iEND,
    input  oDATA, oDVAL, oX_Cont, oY_Cont, oFrame_Cont
  );

  // Capture stage side.
  modport slave (
    input  iDATA, iFVAL, iLVAL, iSTART, iEND,
    output oDATA, oDVAL, oX_Cont, oY_Cont, oFrame_Cont
  );
endinterface
`default_nettype wire

// File: rtl/ccd_capture.sv
`default_nettype none
// ============================================================================
// Module   : ccd_capture
// Brief    : Raw sensor capture front end. Registers sensor data/strobes,
//            gates whole frames under start/stop control, and produces the
//            pixel stream with column/row indices and a frame counter.
// Revision : 1.0  initial release
// ============================================================================
module ccd_capture #(
  parameter int COLUMN_WIDTH = 1280,
  parameter int DATA_W       = 10
) (
  input  wire           iCLK,
  input  wire           iRST,
  ccd_capture_if.slave  bus
);

  localparam logic [10:0] X_LAST = 11'(COLUMN_WIDTH - 1);

  // Stage 1 sensor registers
  logic [DATA_W-1:0] data_q;
  logic              fval_q;
  logic              lval_q;
  logic              prev_fval_q;

  // Control state
  logic              run_q,   run_d;
  logic              fg_q,    fg_d;

  // Next-pixel index (position the next valid pixel will be reported at)
  logic [10:0]       nx_q,    nx_d;
  logic [10:0]       ny_q,    ny_d;

  // Stage 2 output registers
  logic [DATA_W-1:0] odata_q, odata_d;
  logic              odval_q, odval_d;
  logic [10:0]       ox_q,    ox_d;
  logic [10:0]       oy_q,    oy_d;
  logic [31:0]       frame_q, frame_d;

  logic              fval_rise;
  logic              fval_fall;
  logic              pix_valid;

  // Stage 1: sample the sensor every cycle. FVAL and its delayed copy both
  // come out of reset high so a frame already running at reset release
  // never looks like a rising edge.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      data_q      <= '0;
      fval_q      <= 1'b1;
      lval_q      <= 1'b0;
      prev_fval_q <= 1'b1;
    end else begin
      data_q      <= bus.iDATA;
      fval_q      <= bus.iFVAL;
      lval_q      <= bus.iLVAL;
      prev_fval_q <= fval_q;
    end
  end

  // Next-state logic: run flag, frame gate, counters and stage-2 outputs.
  // The gate's next value is used directly for this pixel so that FVAL
  // gating has the same two-edge latency as data and LVAL.
  always_comb begin
    fval_rise = fval_q & ~prev_fval_q;
    fval_fall = ~fval_q & prev_fval_q;

    run_d = run_q;
    if (bus.iEND)        run_d = 1'b0;
    else if (bus.iSTART) run_d = 1'b1;

    fg_d = fg_q;
    if (fval_rise)      fg_d = run_q;
    else if (fval_fall) fg_d = 1'b0;

    pix_valid = fg_d & lval_q;

    odata_d = lval_q ? data_q : '0;
    odval_d = pix_valid;

    nx_d = nx_q;
    ny_d = ny_q;
    ox_d = ox_q;
    oy_d = oy_q;
    if (!fg_d) begin
      nx_d = '0;
      ny_d = '0;
      ox_d = '0;
      oy_d = '0;
    end else if (pix_valid) begin
      ox_d = nx_q;
      oy_d = ny_q;
      if (nx_q == X_LAST) begin
        nx_d = '0;
        ny_d = ny_q + 11'd1;
      end else begin
        nx_d = nx_q + 11'd1;
      end
    end

    frame_d = frame_q;
    if (fval_rise && run_q) frame_d = frame_q + 32'd1;
  end

  // Stage 2 and control registers.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      run_q   <= 1'b0;
      fg_q    <= 1'b0;
      nx_q    <= '0;
      ny_q    <= '0;
      odata_q <= '0;
      odval_q <= 1'b0;
      ox_q    <= '0;
      oy_q    <= '0;
      frame_q <= '0;
    end else begin
      run_q   <= run_d;
      fg_q    <= fg_d;
      nx_q    <= nx_d;
      ny_q    <= ny_d;
      odata_q <= odata_d;
      odval_q <= odval_d;
      ox_q    <= ox_d;
      oy_q    <= oy_d;
      frame_q <= frame_d;
    end
  end

  assign bus.oDATA       = odata_q;
  assign bus.oDVAL       = odval_q;
  assign bus.oX_Cont     = ox_q;
  assign bus.oY_Cont     = oy_q;
  assign bus.oFrame_Cont = frame_q;

endmodule
`default_nettype wire

// File: doc/ccd_capture.md
Name: ccd_capture

Overview:
- Front-end capture stage for the camera pixel path; sits directly upstream of the Bayer demosaic stage.
- Samples raw sensor data with frame/line valid strobes.
- Gates whole frames with start/stop run control.
- Produces the pixel stream, its valid strobe, and the column/row counters the demosaic stage uses for Bayer phase selection. Also counts captured frames.

Parameters:
- COLUMN_WIDTH, 1280, active pixels per line; X counter wraps at COLUMN_WIDTH-1; must be even.
- DATA_W, 10, raw pixel width.

Ports:
- iCLK  in  1  pixel clock; all logic on rising edge.
- iRST  in  1  asynchronous, active-low reset.
- iDATA  in  DATA_W  raw sensor pixel.
- iFVAL  in  1  sensor frame valid.
- iLVAL  in  1  sensor line valid.
- iSTART  in  1  level/pulse; arms capture.
- iEND  in  1  level/pulse; disarms capture.
- oDATA  out  DATA_W  captured pixel; 0 when line invalid.
- oDVAL  out  1  pixel valid (frame gated AND line valid).
- oX_Cont  out  11  column index of oDATA.
- oY_Cont  out  11  row index of oDATA.
- oFrame_Cont  out  32  number of accepted frames.

Behaviour:
- Reset (async, iRST=0): all outputs 0; run flag 0; internal frame-gate 0. Previous-FVAL register resets to 1, so a frame already in progress at reset release is never accepted.
- Stage 1: register iDATA, iFVAL, iLVAL every cycle (no enable).
- Run flag:
  - Set on iSTART=1, cleared on iEND=1.
  - Both high in the same cycle: iEND wins, flag = 0.
- Frame gate (FG):
  - Rises on the registered-FVAL rising edge, only if the run flag = 1 in that cycle.
  - Falls on the registered-FVAL falling edge, regardless of the run flag.
  - iEND mid-frame lets the current frame complete; iSTART mid-frame waits for the next rising edge.
- Outputs (stage 2):
  - oDVAL = FG & registered LVAL.
  - oDATA = registered data when registered LVAL = 1, else 0.
  - Latency from iDATA/iLVAL sample to oDATA/oDVAL: exactly 2 iCLK edges; FVAL gating aligned identically.
- Counters:
  - All counter updates occur only while FG = 1.
  - When FG = 0: X = 0 and Y = 0, held.
  - Each oDVAL=1 pixel carries its own X/Y. X increments after each valid pixel.
  - When X = COLUMN_WIDTH-1 on a valid pixel, X wraps to 0 and Y increments.
  - Y wraps modulo 2048.
  - Line gaps (LVAL low) do not change X/Y.
  - First valid pixel of a frame: X = 0, Y = 0.
- Line length mismatch: a short line does not reset X. Counters follow pixel count only; alignment is recovered at the next frame.
- oFrame_Cont increments by 1 in the cycle FG rises; 32-bit wrap; never reset except by iRST.
- Reset asserted mid-frame: everything clears immediately. After release, the in-progress frame is ignored and capture resumes at the next FVAL rising edge, provided the run flag is set again.

Test Plan:
- Reset, iSTART pulse, FVAL high for 2 lines of COLUMN_WIDTH=8 pixels (iDATA = 1..16), 4-cycle LVAL gaps:
  - 16 oDVAL pulses, oDATA 1..16 appearing 2 cycles after input.
  - X sequence 0..7 twice; Y = 0 then 1.
  - oFrame_Cont = 1.
- No iSTART, 3 frames applied:
  - oDVAL never high; oFrame_Cont stays 0; X/Y stay 0.
- iEND pulse during line 1 of a running frame:
  - Frame completes (all 16 pixels valid).
  - Next frame produces no oDVAL; oFrame_Cont stops at its value.
- iSTART and iEND high in the same cycle before a frame:
  - Frame not captured.
  - iSTART alone afterwards: next frame is captured, oFrame_Cont += 1.
- iRST pulsed low mid-line, with iSTART re-issued:
  - Outputs 0 immediately.
  - Remainder of that frame ignored.
  - Next frame starts at X = 0, Y = 0; oFrame_Cont = 1.
- COLUMN_WIDTH=8 with 9 pixels in one line:
  - 9th pixel reported at X = 0, Y = 1.
  - oFrame_Cont unchanged by the line overrun.
